// File: rtl/siso_loopback_ctrl.sv
// Loopback sequencer for an external DEPTH-stage SISO shift register: clears the chain,
// shifts a word in MSB-first, captures WIDTH bits DEPTH cycles later and flags a match.
module siso_loopback_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ready,
    output logic             busy,
    output logic             sr_reset,
    output logic             sr_serial_in,
    input  logic             sr_serial_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             done,
    output logic             match
);

    localparam int CNT_W = $clog2(WIDTH + DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] tx_sh;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b);
        logic [WIDTH-1:0] r;
        r    = word << 1;
        r[0] = b;
        return r;
    endfunction

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_CLEAR) || (state == S_RUN);

    // tx_sh shifts in zeros, so its MSB naturally becomes the 0 padding after WIDTH bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rx_data      <= '0;
            done         <= 1'b0;
            match        <= 1'b0;
            sr_reset     <= 1'b0;
            sr_serial_in <= 1'b0;
        end else begin
            done         <= 1'b0;
            sr_reset     <= 1'b0;
            sr_serial_in <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        tx_q     <= tx_data;
                        tx_sh    <= tx_data;
                        rx_data  <= '0;
                        cnt      <= '0;
                        match    <= 1'b0;
                        sr_reset <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state        <= S_RUN;
                    sr_serial_in <= tx_sh[WIDTH-1];
                    tx_sh        <= tx_sh << 1;
                end
                S_RUN: begin
                    if (cnt >= CNT_FIRST)
                        rx_data <= shift_in(rx_data, sr_serial_out);
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        match <= (shift_in(rx_data, sr_serial_out) == tx_q);
                    end else begin
                        cnt          <= cnt + 1'b1;
                        sr_serial_in <= tx_sh[WIDTH-1];
                        tx_sh        <= tx_sh << 1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_loopback_ctrl.sv
// Directed bench for siso_loopback_ctrl with a behavioural shift-register chain of selectable depth.
module tb_siso_loopback_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       ready, busy, sr_reset, sr_serial_in, sr_serial_out, done, match;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    int tb_depth = 4;
    logic [7:0] chain = '0;

    siso_loopback_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .ready(ready), .busy(busy), .sr_reset(sr_reset), .sr_serial_in(sr_serial_in),
        .sr_serial_out(sr_serial_out), .rx_data(rx_data), .done(done), .match(match)
    );

    always #5 clk = ~clk;

    // Chain model: a bit driven in cycle k is visible on the output in cycle k+tb_depth
    always @(posedge clk) begin
        if (sr_reset) chain <= '0;
        else          chain <= {chain[6:0], sr_serial_in};
    end
    assign sr_serial_out = chain[tb_depth-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic [7:0] erx, input logic em,
                        input bit poke, input string tag);
        int  n;
        bit  seen;
        tx_data = d;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 30) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, "_ready_low"}, ready, 0);
                if (poke && n == 6) begin
                    start   = 1'b1;
                    tx_data = 8'hFF;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, n, 13);
        check({tag, "_rx"}, rx_data, erx);
        check({tag, "_match"}, match, em);
        if (poke) begin
            start   = 1'b1;
            tx_data = 8'hFF;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_ready"}, ready, 1);
        check({tag, "_done_single"}, done, 0);
        check({tag, "_rx_held"}, rx_data, erx);
    endtask

    initial begin
        logic [7:0] pat;
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        reset   = 1'b1;
        start   = 1'b1;
        tx_data = 8'h00;

        // 1. reset held with start asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", ready, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rx", rx_data, 0);
            check("rst_sin", sr_serial_in, 0);
            check("rst_sreset", sr_reset, 0);
            check("rst_match", match, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_ready", ready, 1);

        // 2. nominal A5, cycle by cycle
        pat     = 8'hA5;
        tx_data = pat;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nom_sreset_clear", sr_reset, 1);
        check("nom_busy_clear", busy, 1);
        check("nom_ready_clear", ready, 0);
        check("nom_sin_clear", sr_serial_in, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("nom_sin_c%0d", c), sr_serial_in, (c < 8) ? pat[7-c] : 1'b0);
            check($sformatf("nom_sreset_c%0d", c), sr_reset, 0);
            check($sformatf("nom_done_c%0d", c), done, 0);
        end
        @(negedge clk);
        check("nom_done", done, 1);
        check("nom_rx", rx_data, 8'hA5);
        check("nom_match", match, 1);
        check("nom_busy_done", busy, 0);
        check("nom_sin_done", sr_serial_in, 0);
        @(negedge clk);
        check("nom_done_drop", done, 0);
        check("nom_ready_back", ready, 1);
        check("nom_match_held", match, 1);

        // 3. start ignored during RUN and DONE
        xfer(8'h3C, 8'h3C, 1'b1, 1'b1, "busyrej");

        // 4. chain one stage longer than DEPTH
        tb_depth = 5;
        xfer(8'hA5, 8'h52, 1'b0, 1'b0, "latmis");
        tb_depth = 4;

        // 5. back-to-back, no residue
        xfer(8'hFF, 8'hFF, 1'b1, 1'b0, "resid1");
        xfer(8'h00, 8'h00, 1'b1, 1'b0, "resid2");

        // 6. reset during RUN c=5
        tx_data = 8'hC3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        check("abort_busy_before", busy, 1);
        check("abort_rx_nonzero", rx_data, 8'h01);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_rx", rx_data, 0);
        check("abort_sreset", sr_reset, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("abort_nodone_%0d", i), done, 0);
            check($sformatf("abort_idle_%0d", i), ready, 1);
        end
        xfer(8'h81, 8'h81, 1'b1, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_loopback_ctrl.md
# siso_loopback_ctrl

Sequencer for an external DEPTH-stage `siso_shift_register`. It accepts a WIDTH-bit word, clears the chain, and shifts the word in MSB-first. It captures the same number of bits from the chain output and reports the received word plus a match flag. It sits beside the shift register as its only driver, used for built-in self-test and for characterizing chain latency.

## Interface
Parameters:
- `WIDTH`, default 8: bits per transfer; must be ≥1.
- `DEPTH`, default 4: stage count of the attached shift register; must be ≥1. Sets the capture offset.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request; accepted on an edge where `start & ready`.
- `tx_data`, input, WIDTH: word to send; sampled on the accept edge.
- `ready`, output, 1: high only in IDLE; combinational from state.
- `busy`, output, 1: high in CLEAR and RUN.
- `sr_reset`, output, 1: registered; drives the shift register's `reset`.
- `sr_serial_in`, output, 1: registered; drives the shift register's `serial_in`.
- `sr_serial_out`, input, 1: the shift register's `serial_out`.
- `rx_data`, output, WIDTH: captured word, MSB first received.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `match`, output, 1: `rx_data == tx_data` as latched at accept; valid when `done` is high, held until the next accept.

## Operation
- States and transitions:
  - IDLE → CLEAR on accept.
  - CLEAR → RUN after one cycle.
  - RUN → DONE when `cnt == WIDTH+DEPTH-1`.
  - DONE → IDLE after one cycle.
- On accept: latch `tx_data` into `tx_q`, clear `rx_data` to 0, set `cnt` to 0.
- CLEAR: `sr_reset` is 1 for exactly this cycle and 0 in every other state. This empties the chain, so earlier transfers leave no residue.
- RUN, in cycle `cnt = c`:
  - For `c < WIDTH`: `sr_serial_in = tx_q[WIDTH-1-c]`. Otherwise `sr_serial_in = 0`.
  - At the edge ending cycle c with `c ≥ DEPTH`: `rx_data <= {rx_data[WIDTH-2:0], sr_serial_out}`.
  - `cnt` increments each RUN cycle.
  - `cnt` width is `clog2(WIDTH+DEPTH)`; it never wraps because the exit happens at its terminal value.
- DONE: `done = 1` and `match` is computed from the final `rx_data` and `tx_q`.
- Chain model: a bit driven in cycle k appears on `sr_serial_out` during cycle k+DEPTH. Capture cycles DEPTH..DEPTH+WIDTH-1 therefore return `tx_q` exactly for a correct chain.
- `start` outside IDLE, including during DONE, is ignored. It is not queued.
- `sr_serial_in` is 0 in IDLE, CLEAR and DONE.

## Timing
- Reset values: state IDLE, `ready = 1`, `busy = 0`, `sr_reset = 0`, `sr_serial_in = 0`, `rx_data = 0`, `done = 0`, `match = 0`, `cnt = 0`.
- Accept edge E0 produces:
  - CLEAR during E0..E1;
  - RUN c=0 after E1;
  - RUN c after E(1+c);
  - DONE after E(WIDTH+DEPTH+1);
  - IDLE (`ready = 1`) after E(WIDTH+DEPTH+2).
- Latency from accept to `done` is WIDTH+DEPTH+1 cycles. For defaults this is 13.
- Back-to-back: the next accept is possible at the edge ending the first IDLE cycle after DONE. Throughput is one transfer per WIDTH+DEPTH+3 cycles.
- `reset` in any state wins over every other action:
  - next cycle is IDLE with all reset values;
  - an aborted transfer produces no `done`;
  - `sr_reset` is not asserted by the abort itself.
- `start` and `reset` together: reset wins and nothing is accepted.

## Test plan
1. Reset: hold `reset` for 2 cycles with `start=1` → `ready=1`, `busy=0`, `done=0`, `rx_data=0`, `sr_serial_in=0`, `sr_reset=0` throughout.
2. Nominal, WIDTH=8, DEPTH=4, `tx_data=8'hA5`:
   - `sr_reset` is high one cycle after the accept;
   - `sr_serial_in` follows 1,0,1,0,0,1,0,1 then 0,0,0,0;
   - `done` pulses 13 cycles after accept with `rx_data=8'hA5`, `match=1`.
3. Busy rejection: accept `8'h3C`, then pulse `start` with `tx_data=8'hFF` during RUN and during DONE → exactly one `done` with `rx_data=8'h3C`, and `ready` stays 0 until IDLE.
4. Latency mismatch: bench model of a 5-stage chain with DEPTH=4 and `tx_data=8'hA5` → `rx_data=8'h52`, `match=0`.
5. Residue clearing: transfer `8'hFF`, then `8'h00` back-to-back → second result is `rx_data=8'h00`, `match=1`.
6. Reset mid-RUN at c=5 → no `done`, next cycle `ready=1` and `rx_data=0`; a following `8'h81` transfer completes with `match=1`.
